// File: rtl/spi_i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_i2s_pkg
// Brief    : Shared state encoding, frame-size codes and size decode helper
//            for the SPI transmit serializer.
// Revision : 1.0 - initial release
// ============================================================================
package spi_i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_8  = 2'd0;
    localparam logic [1:0] SZ_16 = 2'd1;
    localparam logic [1:0] SZ_24 = 2'd2;
    localparam logic [1:0] SZ_32 = 2'd3;

    function automatic logic [5:0] size_to_bits(input logic [1:0] size_sel);
        logic [5:0] bits;
        case (size_sel)
            SZ_8:    bits = 6'd8;
            SZ_16:   bits = 6'd16;
            SZ_24:   bits = 6'd24;
            default: bits = 6'd32;
        endcase
        return bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_i2s_tx_shifter_sck_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_i2s_sck_gen
// Brief    : SCK half-period divider, SCK toggle register and edge counter.
// Revision : 1.0 - initial release
// ============================================================================
module spi_i2s_sck_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             run_i,
    input  logic             idle_i,
    input  logic             cpol_i,
    input  logic [DIV_W-1:0] clk_div_i,
    output logic             sck_o,
    output logic             tick_o,
    output logic [5:0]       edge_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] lim_q;
    logic [5:0]       edge_q;
    logic             sck_q;

    assign tick_o = run_i && (div_q == lim_q);
    assign sck_o  = sck_q;
    assign edge_o = edge_q;

    // The divider limit is captured at frame start so a live clk_div change
    // cannot stretch or shrink SCK phases inside a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            lim_q  <= '0;
            edge_q <= '0;
            sck_q  <= 1'b0;
        end else if (start_i) begin
            div_q  <= '0;
            lim_q  <= clk_div_i;
            edge_q <= '0;
            sck_q  <= cpol_i;
        end else if (run_i) begin
            if (tick_o) begin
                div_q  <= '0;
                edge_q <= edge_q + 6'd1;
                sck_q  <= ~sck_q;
            end else begin
                div_q  <= div_q + DIV_W'(1);
            end
        end else if (idle_i) begin
            sck_q <= cpol_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_i2s_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_i2s_tx_shifter
// Brief    : SPI-master transmit serializer fed from the TX FIFO read port;
//            8/16/24/32-bit frames, programmable CPOL/CPHA/bit order/divider.
// Revision : 1.0 - initial release
// ============================================================================
module spi_i2s_tx_shifter
    import spi_i2s_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       size_select,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsb_first,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [3:0]       fifo_fill,
    input  logic [31:0]      fifo_data,
    output logic             fifo_read,
    output logic             sck,
    output logic             mosi,
    output logic             cs_n,
    output logic             busy,
    output logic             underrun
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] shreg_q;
    logic [5:0]  nbits_q;
    logic [5:0]  bit_cnt_q;
    logic        cpha_q;
    logic        lsb_q;
    logic        mosi_q;
    logic        cs_n_q;

    logic        w_tick;
    logic [5:0]  w_edge;
    logic [5:0]  w_nbits;
    logic [31:0] w_aligned;
    logic [31:0] w_load_shift;
    logic        w_first;
    logic        w_cur_bit;
    logic [31:0] w_next_shreg;
    logic [5:0]  w_last_edge;
    logic        w_last_tick;
    logic        w_leading;
    logic        w_drive;
    logic        w_fifo_has;

    spi_i2s_sck_gen #(
        .DIV_W (DIV_W)
    ) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .start_i   (state_q == ST_LOAD),
        .run_i     (state_q == ST_SHIFT),
        .idle_i    (state_q == ST_IDLE),
        .cpol_i    (cpol),
        .clk_div_i (clk_div),
        .sck_o     (sck),
        .tick_o    (w_tick),
        .edge_o    (w_edge)
    );

    // MSB-first frames are left-justified so the outgoing bit is always bit 31;
    // LSB-first frames stay right-justified and leave through bit 0.
    assign w_nbits      = size_to_bits(size_select);
    assign w_aligned    = lsb_first ? fifo_data : (fifo_data << (6'd32 - w_nbits));
    assign w_first      = lsb_first ? w_aligned[0] : w_aligned[31];
    assign w_load_shift = lsb_first ? (w_aligned >> 1) : (w_aligned << 1);
    assign w_cur_bit    = lsb_q ? shreg_q[0] : shreg_q[31];
    assign w_next_shreg = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);

    // 2N-1 wraps correctly in 6 bits for N=32 (64-1 = 63).
    assign w_last_edge  = (nbits_q << 1) - 6'd1;
    assign w_last_tick  = w_tick && (w_edge == w_last_edge);
    assign w_leading    = ~w_edge[0];
    assign w_drive      = w_tick && (cpha_q ? w_leading : (!w_leading && (bit_cnt_q != 6'd0)));
    assign w_fifo_has   = (fifo_fill != 4'd0);

    assign busy = (state_q != ST_IDLE);
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fifo_read = 1'b0;
        underrun  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && w_fifo_has) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fifo_read = 1'b1;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last_tick) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (enable && w_fifo_has) begin
                    state_d = ST_LOAD;
                end else begin
                    underrun = enable;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q   <= '0;
            nbits_q   <= '0;
            bit_cnt_q <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    nbits_q   <= w_nbits;
                    bit_cnt_q <= w_nbits - 6'd1;
                    cpha_q    <= cpha;
                    lsb_q     <= lsb_first;
                    cs_n_q    <= 1'b0;
                    if (!cpha) begin
                        mosi_q  <= w_first;
                        shreg_q <= w_load_shift;
                    end else begin
                        shreg_q <= w_aligned;
                    end
                end
                ST_SHIFT: begin
                    if (w_drive) begin
                        mosi_q  <= w_cur_bit;
                        shreg_q <= w_next_shreg;
                        if (bit_cnt_q != 6'd0) begin
                            bit_cnt_q <= bit_cnt_q - 6'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (state_d == ST_IDLE) begin
                        cs_n_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_i2s_tx_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_i2s_tx_shifter
// Brief    : Scoreboard bench for the SPI transmit serializer with a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_i2s_tx_shifter;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [1:0]       size_select = 2'd0;
    logic             cpol = 1'b0;
    logic             cpha = 1'b0;
    logic             lsb_first = 1'b0;
    logic [DIV_W-1:0] clk_div = '0;
    logic [3:0]       fifo_fill;
    logic [31:0]      fifo_data;
    logic             fifo_read, sck, mosi, cs_n, busy, underrun;

    logic [31:0] fifo_mem [0:63];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          overpop_cnt = 0;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];

    int cyc = 0, n_samp, n_tog, n_read, n_under, n_cs_low, n_cs_rise, under_at_read;
    int last_samp, last_read, sb_gap, read_gap;
    logic prev_sck = 1'b0, prev_cs_n = 1'b1, seen_busy;
    logic sb_ev, sb_empty, sb_got, sb_exp;

    spi_i2s_tx_shifter #(.DIV_W(DIV_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .size_select (size_select),
        .cpol        (cpol),
        .cpha        (cpha),
        .lsb_first   (lsb_first),
        .clk_div     (clk_div),
        .fifo_fill   (fifo_fill),
        .fifo_data   (fifo_data),
        .fifo_read   (fifo_read),
        .sck         (sck),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    assign fifo_fill = 4'(wr_cnt - rd_cnt);
    assign fifo_data = fifo_mem[rd_cnt[5:0]];

    always @(posedge clk) begin
        if (fifo_read) begin
            if (wr_cnt == rd_cnt) overpop_cnt <= overpop_cnt + 1;
            else                  rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic push_word(input logic [31:0] w, input int nbits, input bit lsb, input bit track);
        fifo_mem[wr_cnt[5:0]] = w;
        wr_cnt++;
        if (track) begin
            for (int i = 0; i < nbits; i++) exp_q.push_back(lsb ? w[i] : w[nbits-1-i]);
        end
    endtask

    task automatic clear_stats();
        n_samp = 0; n_tog = 0; n_read = 0; n_under = 0; n_cs_low = 0; n_cs_rise = 0;
        under_at_read = -1; last_samp = 0; last_read = 0; seen_busy = 1'b0;
    endtask

    // Advance one clock and sample just after the edge; on each data-capture
    // SCK edge (leading for CPHA=0, trailing for CPHA=1) pop the scoreboard.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sb_ev = 1'b0;
        if (!cs_n && sck !== prev_sck) begin
            n_tog++;
            if (sck === (cpol ^ ~cpha)) begin
                sb_ev = 1'b1;
                n_samp++;
                sb_gap = cyc - last_samp;
                last_samp = cyc;
                sb_got = mosi;
                sb_empty = (exp_q.size() == 0);
                if (sb_empty) sb_exp = 1'b0;
                else          sb_exp = exp_q.pop_front();
            end
        end
        if (fifo_read) begin
            n_read++;
            read_gap = cyc - last_read;
            last_read = cyc;
        end
        if (underrun) begin
            n_under++;
            under_at_read = n_read;
        end
        if (!cs_n) n_cs_low++;
        if (cs_n && !prev_cs_n) n_cs_rise++;
        if (busy) seen_busy = 1'b1;
        prev_sck = sck;
        prev_cs_n = cs_n;
    endtask

    task automatic test_reset();
        exp_q.delete();
        clear_stats();
        rst = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        size_select = 2'd0; clk_div = '0;
        push_word(32'h0000_005A, 8, 1'b0, 1'b1);
        push_word(32'hFFFF_FFC3, 8, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (sck !== 1'b0)       begin n_err++; $display("FAIL reset_sck c%0d: got %b want 0", c, sck); end
            n_cmp++; if (cs_n !== 1'b1)      begin n_err++; $display("FAIL reset_cs_n c%0d: got %b want 1", c, cs_n); end
            n_cmp++; if (fifo_read !== 1'b0) begin n_err++; $display("FAIL reset_fifo_read c%0d: got %b want 0", c, fifo_read); end
            n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy c%0d: got %b want 0", c, busy); end
            n_cmp++; if (mosi !== 1'b0)      begin n_err++; $display("FAIL reset_mosi c%0d: got %b want 0", c, mosi); end
        end
        rst = 1'b0;
        clear_stats();
        step();
        n_cmp++; if (fifo_read !== 1'b1) begin n_err++; $display("FAIL reset_release_load: fifo_read=%b want 1", fifo_read); end
        for (int c = 0; c < 200 && !(seen_busy && !busy); c++) begin
            step();
            if (sb_ev) begin
                n_cmp++;
                if (sb_empty || sb_got !== sb_exp) begin n_err++; $display("FAIL reset_frame_bit%0d: mosi=%b want=%b empty=%0d", n_samp, sb_got, sb_exp, sb_empty); end
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_frame_timeout: busy=%b want 0", busy); end
        n_cmp++; if (n_read != 2)   begin n_err++; $display("FAIL reset_frame_reads: got %0d want 2", n_read); end
        n_cmp++; if (n_samp != 16)  begin n_err++; $display("FAIL reset_frame_bits: got %0d want 16", n_samp); end
    endtask

    task automatic test_single_frame();
        exp_q.delete();
        clear_stats();
        size_select = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1; enable = 1'b1;
        push_word(32'h7777_77A5, 8, 1'b0, 1'b1);
        for (int c = 0; c < 200 && !(seen_busy && !busy); c++) begin
            step();
            if (sb_ev) begin
                n_cmp++;
                if (sb_empty || sb_got !== sb_exp) begin n_err++; $display("FAIL single_bit%0d: mosi=%b want=%b empty=%0d", n_samp, sb_got, sb_exp, sb_empty); end
                if (n_samp > 1) begin
                    n_cmp++; if (sb_gap != 4) begin n_err++; $display("FAIL single_sck_period pulse%0d: got %0d want 4", n_samp, sb_gap); end
                end
            end
        end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL single_timeout: busy=%b want 0", busy); end
        n_cmp++; if (n_read != 1)    begin n_err++; $display("FAIL single_reads: got %0d want 1", n_read); end
        n_cmp++; if (n_samp != 8)    begin n_err++; $display("FAIL single_pulses: got %0d want 8", n_samp); end
        n_cmp++; if (n_cs_low != 33) begin n_err++; $display("FAIL single_cs_low: got %0d want 33", n_cs_low); end
        n_cmp++; if (n_under != 1)   begin n_err++; $display("FAIL single_underrun: got %0d want 1", n_under); end
        n_cmp++; if (cs_n !== 1'b1)  begin n_err++; $display("FAIL single_cs_idle: got %b want 1", cs_n); end
    endtask

    task automatic test_mode3_lsb32();
        exp_q.delete();
        cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1; size_select = 2'd3; clk_div = 8'd0; enable = 1'b1;
        step(); step();
        n_cmp++; if (sck !== 1'b1) begin n_err++; $display("FAIL mode3_sck_idle: got %b want 1", sck); end
        clear_stats();
        push_word(32'h8000_0001, 32, 1'b1, 1'b1);
        for (int c = 0; c < 300 && !(seen_busy && !busy); c++) begin
            step();
            if (sb_ev) begin
                n_cmp++;
                if (sb_empty || sb_got !== sb_exp) begin n_err++; $display("FAIL mode3_bit%0d: mosi=%b want=%b empty=%0d", n_samp, sb_got, sb_exp, sb_empty); end
                if (n_samp > 1) begin
                    n_cmp++; if (sb_gap != 2) begin n_err++; $display("FAIL mode3_sck_period pulse%0d: got %0d want 2", n_samp, sb_gap); end
                end
            end
        end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL mode3_timeout: busy=%b want 0", busy); end
        n_cmp++; if (n_samp != 32)   begin n_err++; $display("FAIL mode3_pulses: got %0d want 32", n_samp); end
        n_cmp++; if (n_cs_low != 65) begin n_err++; $display("FAIL mode3_frame_len: got %0d want 65", n_cs_low); end
        n_cmp++; if (sck !== 1'b1)   begin n_err++; $display("FAIL mode3_sck_end: got %b want 1", sck); end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; size_select = 2'd0; clk_div = 8'd0; enable = 1'b1;
        step(); step();
        clear_stats();
        push_word(32'h0000_0011, 8, 1'b0, 1'b1);
        push_word(32'h0000_0022, 8, 1'b0, 1'b1);
        push_word(32'h0000_0033, 8, 1'b0, 1'b1);
        for (int c = 0; c < 300 && !(seen_busy && !busy); c++) begin
            step();
            if (sb_ev) begin
                n_cmp++;
                if (sb_empty || sb_got !== sb_exp) begin n_err++; $display("FAIL b2b_bit%0d: mosi=%b want=%b empty=%0d", n_samp, sb_got, sb_exp, sb_empty); end
            end
            if (fifo_read && n_read > 1) begin
                n_cmp++; if (read_gap != 18) begin n_err++; $display("FAIL b2b_frame_gap read%0d: got %0d want 18", n_read, read_gap); end
            end
        end
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL b2b_timeout: busy=%b want 0", busy); end
        n_cmp++; if (n_read != 3)       begin n_err++; $display("FAIL b2b_reads: got %0d want 3", n_read); end
        n_cmp++; if (n_cs_low != 53)    begin n_err++; $display("FAIL b2b_cs_low: got %0d want 53", n_cs_low); end
        n_cmp++; if (n_cs_rise != 1)    begin n_err++; $display("FAIL b2b_cs_rises: got %0d want 1", n_cs_rise); end
        n_cmp++; if (n_under != 1)      begin n_err++; $display("FAIL b2b_underruns: got %0d want 1", n_under); end
        n_cmp++; if (under_at_read != 3) begin n_err++; $display("FAIL b2b_underrun_when: after read %0d want 3", under_at_read); end
        n_cmp++; if (overpop_cnt != 0)  begin n_err++; $display("FAIL b2b_overpop: got %0d want 0", overpop_cnt); end
    endtask

    task automatic test_enable_drop();
        exp_q.delete();
        cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; size_select = 2'd1; clk_div = 8'd2; enable = 1'b1;
        step(); step();
        clear_stats();
        push_word(32'hDEAD_BEEF, 16, 1'b0, 1'b1);
        // Second word stays queued; it feeds the mid-frame reset test next.
        push_word(32'h1234_5678, 32, 1'b0, 1'b0);
        for (int c = 0; c < 400 && !(seen_busy && !busy); c++) begin
            step();
            if (enable && n_tog >= 5) enable = 1'b0;
            if (sb_ev) begin
                n_cmp++;
                if (sb_empty || sb_got !== sb_exp) begin n_err++; $display("FAIL drop_bit%0d: mosi=%b want=%b empty=%0d", n_samp, sb_got, sb_exp, sb_empty); end
                if (n_samp > 1) begin
                    n_cmp++; if (sb_gap != 6) begin n_err++; $display("FAIL drop_sck_period pulse%0d: got %0d want 6", n_samp, sb_gap); end
                end
            end
        end
        for (int c = 0; c < 4; c++) step();
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL drop_timeout: busy=%b want 0", busy); end
        n_cmp++; if (n_samp != 16)    begin n_err++; $display("FAIL drop_pulses: got %0d want 16", n_samp); end
        n_cmp++; if (n_cs_low != 97)  begin n_err++; $display("FAIL drop_cs_low: got %0d want 97", n_cs_low); end
        n_cmp++; if (n_under != 0)    begin n_err++; $display("FAIL drop_underrun: got %0d want 0", n_under); end
        n_cmp++; if (n_read != 1)     begin n_err++; $display("FAIL drop_reads: got %0d want 1", n_read); end
        n_cmp++; if (fifo_fill !== 4'd1) begin n_err++; $display("FAIL drop_fill: got %0d want 1", fifo_fill); end
        n_cmp++; if (cs_n !== 1'b1)   begin n_err++; $display("FAIL drop_cs_idle: got %b want 1", cs_n); end
    endtask

    task automatic test_reset_mid_shift();
        exp_q.delete();
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; size_select = 2'd3; clk_div = 8'd0;
        step(); step();
        clear_stats();
        enable = 1'b1;
        for (int c = 0; c < 100 && n_tog < 7; c++) step();
        n_cmp++; if (n_tog != 7)    begin n_err++; $display("FAIL rstmid_reach_edge7: got %0d edges want 7", n_tog); end
        n_cmp++; if (mosi !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_mosi: got %b want 1", mosi); end
        n_cmp++; if (sck !== 1'b1)  begin n_err++; $display("FAIL rstmid_pre_sck: got %b want 1", sck); end
        rst = 1'b1;
        enable = 1'b0;
        step();
        n_cmp++; if (sck !== 1'b0)       begin n_err++; $display("FAIL rstmid_sck: got %b want 0", sck); end
        n_cmp++; if (cs_n !== 1'b1)      begin n_err++; $display("FAIL rstmid_cs_n: got %b want 1", cs_n); end
        n_cmp++; if (mosi !== 1'b0)      begin n_err++; $display("FAIL rstmid_mosi: got %b want 0", mosi); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (fifo_read !== 1'b0) begin n_err++; $display("FAIL rstmid_fifo_read: got %b want 0", fifo_read); end
        rst = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rstmid_post_busy: got %b want 0", busy); end
        n_cmp++; if (fifo_fill !== 4'd0)  begin n_err++; $display("FAIL rstmid_word_lost: fill=%0d want 0", fifo_fill); end
        n_cmp++; if (overpop_cnt != 0)    begin n_err++; $display("FAIL rstmid_overpop: got %0d want 0", overpop_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_mode3_lsb32();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
